jesd204_versal_gt_adapter_tx: RTL and testbench

Transmit-side adapter between the JESD204 TX link layer and a Versal GT transmitter. It supports 8B10B and 64B66B link modes and registers link data onto the GT TX interface. In 64B66B mode it bit-reverses data and swaps the two sync-header bits. A startup state machine holds the GT on a fixed idle pattern until the GT TX path has been stably ready for 32 cycles.

---
 rtl/jesd204_versal_gt_adapter_pkg.sv | 56 +++++
 rtl/jesd204_tx_prbs31_gen.sv | 27 ++
 rtl/jesd204_versal_gt_adapter_tx.sv | 138 +++++++++++++
 tb/tb_jesd204_versal_gt_adapter_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204_versal_gt_adapter_pkg.sv
// Shared constants, types and helpers for the JESD204 Versal GT TX adapter.
package jesd204_versal_gt_adapter_pkg;

   localparam int LINK_MODE_8B10B  = 1;
   localparam int LINK_MODE_64B66B = 2;

   // GT TX path must be ready for READY_CNT_MAX+1 consecutive cycles
   localparam int READY_CNT_MAX = 31;
   localparam int READY_CNT_W   = 6;

   // 64B66B data-block sync header, also used as the idle header
   localparam logic [1:0] HDR_DATA = 2'b01;

   // PRBS31: x^31 + x^28 + 1
   localparam int                PRBS_W      = 31;
   localparam int                PRBS_TAP_HI = 31;
   localparam int                PRBS_TAP_LO = 28;
   localparam logic [PRBS_W-1:0] PRBS_SEED   = 31'h7FFF_FFFF;
   localparam int                PRBS_WORD_W = 64;

   typedef enum logic {
      ST_WAIT   = 1'b0,
      ST_ACTIVE = 1'b1
   } tx_state_t;

   typedef struct packed {
      logic [PRBS_W-1:0]      state;
      logic [PRBS_WORD_W-1:0] word;
   } prbs_step_t;

   // Mirror a 64-bit word: out[63-i] = in[i]
   function automatic logic [63:0] bit_reverse64(input logic [63:0] d);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < 64; i++) r[63-i] = d[i];
      return r;
   endfunction

   // Run the PRBS31 LFSR 64 steps; word[0] is the first generated bit.
   // state[0] holds the newest bit, state[30] the oldest.
   function automatic prbs_step_t prbs31_step64(input logic [PRBS_W-1:0] seed);
      prbs_step_t        r;
      logic [PRBS_W-1:0] s;
      logic              nb;
      s      = seed;
      r.word = '0;
      for (int i = 0; i < PRBS_WORD_W; i++) begin
         nb        = s[PRBS_TAP_HI-1] ^ s[PRBS_TAP_LO-1];
         r.word[i] = nb;
         s         = {s[PRBS_W-2:0], nb};
      end
      r.state = s;
      return r;
   endfunction

endpackage

// File: rtl/jesd204_tx_prbs31_gen.sv
// PRBS31 word generator, 64 bits per advance, seeded all-ones on reset.
module jesd204_tx_prbs31_gen
   import jesd204_versal_gt_adapter_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        advance,
   output logic [63:0] prbs_word
);

   logic [PRBS_W-1:0] lfsr_q;
   prbs_step_t        step;

   // Next 64 sequence bits from the current LFSR state
   always_comb begin
      step = prbs31_step64(lfsr_q);
   end

   assign prbs_word = step.word;

   // Hold the LFSR unless the consumer takes the current word
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        lfsr_q <= PRBS_SEED;
      else if (advance) lfsr_q <= step.state;
   end

endmodule

// File: rtl/jesd204_versal_gt_adapter_tx.sv
// JESD204 TX link layer to Versal GT TX adapter (8B10B / 64B66B).
// Holds the GT on an idle pattern until the TX path has been ready for
// 32 consecutive cycles, then registers link data onto the GT interface.
// Optional PRBS31 test source: define JESD204_TX_PRBS_EN.
module jesd204_versal_gt_adapter_tx
   import jesd204_versal_gt_adapter_pkg::*;
#(
   parameter int LINK_MODE = 2
)(
   input  logic         usr_clk,
   input  logic         rstn,
   input  logic [63:0]  tx_data,
   input  logic [3:0]   tx_charisk,
   input  logic [1:0]   tx_header,
   input  logic         gt_tx_ready,
   input  logic         prbs_en,
   output logic [127:0] txdata,
   output logic [5:0]   txheader,
   output logic [15:0]  txctrl0,
   output logic [15:0]  txctrl1,
   output logic [7:0]   txctrl2,
   output logic         tx_link_up
);

   // Anything other than 64B66B is treated as 8B10B
   localparam bit IS_64B66B = (LINK_MODE == LINK_MODE_64B66B);

   tx_state_t              state, state_nxt;
   logic [READY_CNT_W-1:0] ready_cnt, ready_cnt_nxt;

   logic [63:0] src_data;
   logic [1:0]  src_hdr;
   logic [3:0]  src_k;
   logic [63:0] data_nxt, data_q;
   logic [1:0]  hdr_nxt, hdr_q;
   logic [3:0]  k_nxt, k_q;

`ifdef JESD204_TX_PRBS_EN
   logic [63:0] prbs_word;
   logic        prbs_sel;

   assign prbs_sel = (state == ST_ACTIVE) && prbs_en;

   jesd204_tx_prbs31_gen u_prbs (
      .clk       (usr_clk),
      .rstn      (rstn),
      .advance   (prbs_sel),
      .prbs_word (prbs_word)
   );
`else
   // Port kept for interface stability; no PRBS source in this build
   logic unused_prbs_en;
   assign unused_prbs_en = prbs_en;
`endif

   // Startup FSM: count consecutive ready cycles, fall back on any drop
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_nxt     = state;
      ready_cnt_nxt = ready_cnt;
      unique case (state)
         ST_WAIT: begin
            if (!gt_tx_ready) begin
               ready_cnt_nxt = '0;
            end else if (ready_cnt == READY_CNT_W'(READY_CNT_MAX)) begin
               state_nxt     = ST_ACTIVE;
               ready_cnt_nxt = '0;
            end else begin
               ready_cnt_nxt = ready_cnt + READY_CNT_W'(1);
            end
         end
         ST_ACTIVE: begin
            ready_cnt_nxt = '0;
            if (!gt_tx_ready) state_nxt = ST_WAIT;
         end
         default: begin
            state_nxt     = ST_WAIT;
            ready_cnt_nxt = '0;
         end
      endcase
   end

   // FSM state and ready counter registers
   always_ff @(posedge usr_clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rstn) begin
         state     <= ST_WAIT;
         ready_cnt <= '0;
      end else begin
         state     <= state_nxt;
         ready_cnt <= ready_cnt_nxt;
      end
   end

   // Source select (idle / link / PRBS) and mode-specific formatting
   always_comb begin
      src_data = 64'h0;
      src_hdr  = HDR_DATA;
      src_k    = 4'h0;
      if (state == ST_ACTIVE) begin
         src_data = tx_data;
         src_hdr  = tx_header;
         src_k    = tx_charisk;
`ifdef JESD204_TX_PRBS_EN
         if (prbs_en) begin
            src_data = prbs_word;
            src_hdr  = HDR_DATA;
            src_k    = 4'h0;
         end
`endif
      end
      // GT expects MSB-first bit order and swapped sync header in 64B66B
      data_nxt = IS_64B66B ? bit_reverse64(src_data) : {32'h0, src_data[31:0]};
      hdr_nxt  = IS_64B66B ? {src_hdr[0], src_hdr[1]} : 2'b00;
      k_nxt    = IS_64B66B ? 4'h0 : src_k;
   end

   // Single output register stage onto the GT TX interface
   always_ff @(posedge usr_clk or negedge rstn) begin
      if (!rstn) begin
         data_q <= '0;
         hdr_q  <= '0;
         k_q    <= '0;
      end else begin
         data_q <= data_nxt;
         hdr_q  <= hdr_nxt;
         k_q    <= k_nxt;
      end
   end

   assign txdata     = {64'h0, data_q};
   assign txheader   = {4'h0, hdr_q};
   assign txctrl0    = 16'h0;
   assign txctrl1    = 16'h0;
   assign txctrl2    = {4'h0, k_q};
   assign tx_link_up = (state == ST_ACTIVE);

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_tx.sv
// Self-checking bench for jesd204_versal_gt_adapter_tx. Three instances
// (64B66B, 8B10B, and an out-of-range LINK_MODE expected to act as 8B10B)
// share stimulus; expected outputs go through a scoreboard queue.
module tb_jesd204_versal_gt_adapter_tx;

   typedef struct packed {
      logic [127:0] data;
      logic [5:0]   hdr;
      logic [7:0]   k;
      logic         link;
   } exp_t;

   logic        usr_clk = 1'b0;
   logic        rstn;
   logic [63:0] tx_data;
   logic [3:0]  tx_charisk;
   logic [1:0]  tx_header;
   logic        gt_tx_ready;
   logic        prbs_en;

   logic [127:0] txdata_64, txdata_8, txdata_x;
   logic [5:0]   txheader_64, txheader_8, txheader_x;
   logic [15:0]  txctrl0_64, txctrl0_8, txctrl0_x;
   logic [15:0]  txctrl1_64, txctrl1_8, txctrl1_x;
   logic [7:0]   txctrl2_64, txctrl2_8, txctrl2_x;
   logic         link_64, link_8, link_x;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   exp_t q64[$];
   exp_t q8[$];

   // Reference model state
   bit m_active;
   int m_run;
`ifdef JESD204_TX_PRBS_EN
   bit prbs_hist[$];
`endif

   always #5 usr_clk = ~usr_clk;

   jesd204_versal_gt_adapter_tx #(.LINK_MODE(2)) dut_64 (
      .usr_clk(usr_clk), .rstn(rstn), .tx_data(tx_data), .tx_charisk(tx_charisk),
      .tx_header(tx_header), .gt_tx_ready(gt_tx_ready), .prbs_en(prbs_en),
      .txdata(txdata_64), .txheader(txheader_64), .txctrl0(txctrl0_64),
      .txctrl1(txctrl1_64), .txctrl2(txctrl2_64), .tx_link_up(link_64));

   jesd204_versal_gt_adapter_tx #(.LINK_MODE(1)) dut_8 (
      .usr_clk(usr_clk), .rstn(rstn), .tx_data(tx_data), .tx_charisk(tx_charisk),
      .tx_header(tx_header), .gt_tx_ready(gt_tx_ready), .prbs_en(prbs_en),
      .txdata(txdata_8), .txheader(txheader_8), .txctrl0(txctrl0_8),
      .txctrl1(txctrl1_8), .txctrl2(txctrl2_8), .tx_link_up(link_8));

   jesd204_versal_gt_adapter_tx #(.LINK_MODE(3)) dut_x (
      .usr_clk(usr_clk), .rstn(rstn), .tx_data(tx_data), .tx_charisk(tx_charisk),
      .tx_header(tx_header), .gt_tx_ready(gt_tx_ready), .prbs_en(prbs_en),
      .txdata(txdata_x), .txheader(txheader_x), .txctrl0(txctrl0_x),
      .txctrl1(txctrl1_x), .txctrl2(txctrl2_x), .tx_link_up(link_x));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      n_cmp++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
      end
   endtask

   task automatic check_dut(input string name, input exp_t e, input logic [127:0] d,
                            input logic [5:0] h, input logic [15:0] c0, input logic [15:0] c1,
                            input logic [7:0] c2, input logic lu);
      check({name, ".txdata"},   d,          e.data);
      check({name, ".txheader"}, 128'(h),    128'(e.hdr));
      check({name, ".txctrl0"},  128'(c0),   128'h0);
      check({name, ".txctrl1"},  128'(c1),   128'h0);
      check({name, ".txctrl2"},  128'(c2),   128'(e.k));
      check({name, ".link_up"},  128'(lu),   128'(e.link));
   endtask

   task automatic check_all_zero(input string tag);
      exp_t z;
      z = '0;
      check_dut({tag, ".m64"}, z, txdata_64, txheader_64, txctrl0_64, txctrl1_64, txctrl2_64, link_64);
      check_dut({tag, ".m8"},  z, txdata_8,  txheader_8,  txctrl0_8,  txctrl1_8,  txctrl2_8,  link_8);
      check_dut({tag, ".mx"},  z, txdata_x,  txheader_x,  txctrl0_x,  txctrl1_x,  txctrl2_x,  link_x);
   endtask

   function automatic logic [63:0] mirror(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[63-i] = d[i];
      return r;
   endfunction

`ifdef JESD204_TX_PRBS_EN
   task automatic prbs_model_reset();
      prbs_hist.delete();
      for (int i = 0; i < 31; i++) prbs_hist.push_back(1'b1);
   endtask

   // Sequence recurrence b[n] = b[n-31] ^ b[n-28]; word bit 0 is the earliest bit
   function automatic logic [63:0] prbs_model_next64();
      logic [63:0] w;
      bit          nb;
      for (int i = 0; i < 64; i++) begin
         nb   = prbs_hist[0] ^ prbs_hist[3];
         w[i] = nb;
         prbs_hist.push_back(nb);
         void'(prbs_hist.pop_front());
      end
      return w;
   endfunction
`endif

   task automatic model_reset();
      m_active = 1'b0;
      m_run    = 0;
`ifdef JESD204_TX_PRBS_EN
      prbs_model_reset();
`endif
   endtask

   // Drive one cycle of stimulus, predict the registered outputs, then compare
   task automatic step(input logic rdy, input logic [63:0] d, input logic [1:0] h,
                       input logic [3:0] k, input logic pe);
      exp_t        e64, e8;
      logic [63:0] src;
      logic [1:0]  sh;
      logic [3:0]  sk;
      gt_tx_ready = rdy;
      tx_data     = d;
      tx_header   = h;
      tx_charisk  = k;
      prbs_en     = pe;
      src = 64'h0;
      sh  = 2'b01;
      sk  = 4'h0;
      if (m_active) begin
         src = d;
         sh  = h;
         sk  = k;
`ifdef JESD204_TX_PRBS_EN
         if (pe) begin
            src = prbs_model_next64();
            sh  = 2'b01;
            sk  = 4'h0;
         end
`endif
      end
      if (m_active) begin
         if (!rdy) begin
            m_active = 1'b0;
            m_run    = 0;
         end
      end else begin
         m_run = rdy ? m_run + 1 : 0;
         if (m_run == 32) begin
            m_active = 1'b1;
            m_run    = 0;
         end
      end
      e64.data = {64'h0, mirror(src)};
      e64.hdr  = {4'h0, sh[0], sh[1]};
      e64.k    = 8'h0;
      e64.link = m_active;
      e8.data  = {96'h0, src[31:0]};
      e8.hdr   = 6'h0;
      e8.k     = {4'h0, sk};
      e8.link  = m_active;
      q64.push_back(e64);
      q8.push_back(e8);
      @(posedge usr_clk);
      #1;
      cyc++;
      e64 = q64.pop_front();
      e8  = q8.pop_front();
      check_dut("m64", e64, txdata_64, txheader_64, txctrl0_64, txctrl1_64, txctrl2_64, link_64);
      check_dut("m8",  e8,  txdata_8,  txheader_8,  txctrl0_8,  txctrl1_8,  txctrl2_8,  link_8);
      check_dut("mx",  e8,  txdata_x,  txheader_x,  txctrl0_x,  txctrl1_x,  txctrl2_x,  link_x);
   endtask

   task automatic step_rand(input logic rdy, input logic pe);
      step(rdy, {$urandom, $urandom}, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pe);
   endtask

   initial begin
      rstn        = 1'b0;
      gt_tx_ready = 1'b1;
      tx_data     = 64'h0;
      tx_charisk  = 4'h0;
      tx_header   = 2'b00;
      prbs_en     = 1'b0;
      model_reset();

      // Reset state
      repeat (2) @(posedge usr_clk);
      #1;
      check_all_zero("reset");
      rstn = 1'b1;

      // Ready from the first cycle: 32 idle cycles, link up after the 32nd
      for (int i = 0; i < 32; i++) step_rand(1'b1, 1'b0);

      // First ACTIVE words
      step(1'b1, 64'h0000_0000_0000_0001, 2'b10, 4'h0, 1'b0);
      step(1'b1, 64'h1234_5678_BCBC_BCBC, 2'b01, 4'hF, 1'b0);
      step(1'b1, 64'hFFFF_FFFF_0000_0000, 2'b00, 4'h5, 1'b0);
      for (int i = 0; i < 6; i++) step_rand(1'b1, 1'b0);

      // Ready drop: link down next cycle, idle output the cycle after
      step(1'b1, 64'hA5A5_A5A5_5A5A_5A5A, 2'b10, 4'hA, 1'b0);
      step(1'b0, 64'hDEAD_BEEF_CAFE_F00D, 2'b01, 4'h3, 1'b0);
      step(1'b1, 64'h0123_4567_89AB_CDEF, 2'b10, 4'hC, 1'b0);

      // Glitch after 20 ready cycles restarts the 32-cycle count
      for (int i = 0; i < 19; i++) step_rand(1'b1, 1'b0);
      step_rand(1'b0, 1'b0);
      for (int i = 0; i < 32; i++) step_rand(1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step_rand(1'b1, 1'b1);
      for (int i = 0; i < 4; i++) step_rand(1'b1, 1'($urandom_range(0, 1)));

      // Asynchronous reset mid-cycle clears outputs before the next edge
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(posedge usr_clk);
      #1;
      check_all_zero("held_rst");
      rstn = 1'b1;
      model_reset();

      // Restart, with ready glitches mixed in
      for (int i = 0; i < 10; i++) step_rand(1'b1, 1'b0);
      step_rand(1'b0, 1'b0);
      for (int i = 0; i < 34; i++) step_rand(1'b1, 1'b0);

`ifdef JESD204_TX_PRBS_EN
      // Long PRBS run, including a pause in prbs_en
      for (int i = 0; i < 5000; i++) step_rand(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step_rand(1'b1, 1'b0);
      for (int i = 0; i < 5000; i++) step_rand(1'b1, 1'b1);
`else
      for (int i = 0; i < 8; i++) step_rand(1'b1, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Watchdog: the sequence is fixed-length, this only guards against a stall
   initial begin
      #2_000_000;
      $display("FAIL watchdog: run exceeded time limit (observed timeout, required completion)");
      $fatal(1, "watchdog");
   end

endmodule
